spm_prog_loader: RTL and testbench

//  Program loader and unified memory on the upstream side of RISC_SPM.
//  - Accepts a byte stream over a valid/ready handshake and writes it into a 256x8 memory from address 0.
//  - Holds the processor in reset while loading, then releases it.
//  - Serves the processor's address/data_out/data_in/write memory bus.
//  - Replaces the bench-driven memory behind SPM_IF.

---
 rtl/spm_pkg.sv | 29 ++
 rtl/spm_ram.sv | 32 +++
 rtl/spm_prog_loader.sv | 145 ++++++++++++++
 tb/tb_spm_prog_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the RISC_SPM program loader and unified memory.
// Contents:
//   SPM_ADDR_W / SPM_DATA_W : default bus widths (256 x 8 memory)
//   ld_state_t              : loader FSM states
//   OP_*                    : RISC_SPM opcodes (upper nibble of an instruction byte)
package spm_pkg;

  localparam int SPM_ADDR_W = 8;
  localparam int SPM_DATA_W = 8;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_HOLD,
    LD_RUN
  } ld_state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_RD   = 4'b0101;
  localparam logic [3:0] OP_WR   = 4'b0110;
  localparam logic [3:0] OP_BR   = 4'b0111;
  localparam logic [3:0] OP_BRZ  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

endpackage

// File: rtl/spm_ram.sv
// Unified program/data memory, 2**ADDR_W x DATA_W.
// Ports:
//   clk          : write clock
//   we/waddr/wdata : single synchronous write port
//   raddr/rdata  : asynchronous read port (processor fetches without wait states)
// Contents are not cleared by any reset.
module spm_ram
  import spm_pkg::*;
#(
  parameter int ADDR_W = SPM_ADDR_W,
  parameter int DATA_W = SPM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-during-write at the same address returns the old contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/spm_prog_loader.sv
// Program loader in front of RISC_SPM's memory.
// Streams ld_len bytes (valid/ready) into memory from address 0 while holding
// the processor in reset, keeps reset asserted for a few more cycles, then
// releases the processor and serves its memory bus.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   ld_start, ld_len        : start pulse and byte count (0..256, larger clamps to 256)
//   ld_valid, ld_data       : byte stream in; ld_ready accepts a byte
//   ld_busy, ld_done        : loading/holding indicator, one-cycle pulse on entry to RUN
//   cpu_rst                 : reset to the processor
//   cpu_addr/cpu_wdata/cpu_write/cpu_rdata : processor memory bus
module spm_prog_loader
  import spm_pkg::*;
#(
  parameter int ADDR_W   = SPM_ADDR_W,
  parameter int DATA_W   = SPM_DATA_W,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata
);

  localparam int HC_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   remain_reg, remain_next;
  logic [HC_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic              done_reg, done_next;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W:0]   len_clamped;
  logic              start_ok;

  assign len_clamped = (ld_len > DEPTH) ? DEPTH : ld_len;
  // A start is only meaningful when no load is in progress.
  assign start_ok    = ld_start && (state_reg == LD_IDLE || state_reg == LD_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LD_IDLE;
      wr_ptr_reg   <= '0;
      remain_reg   <= '0;
      hold_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      remain_reg   <= remain_next;
      hold_cnt_reg <= hold_cnt_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    remain_next   = remain_reg;
    hold_cnt_next = hold_cnt_reg;
    done_next     = 1'b0;
    ld_ready      = 1'b0;
    ld_busy       = 1'b0;
    cpu_rst       = 1'b1;
    ram_we        = 1'b0;
    ram_waddr     = wr_ptr_reg;
    ram_wdata     = ld_data;

    case (state_reg)
      LD_IDLE: begin
      end
      LD_LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid) begin
          ram_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
          remain_next = remain_reg - (ADDR_W+1)'(1);
          if (remain_reg == (ADDR_W+1)'(1)) begin
            state_next    = LD_HOLD;
            hold_cnt_next = '0;
          end
        end
      end
      LD_HOLD: begin
        ld_busy = 1'b1;
        // HOLD lasts RST_HOLD+1 cycles: counts 0..RST_HOLD, leaves on RST_HOLD.
        if (hold_cnt_reg == HC_W'(RST_HOLD)) begin
          state_next = LD_RUN;
          done_next  = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + HC_W'(1);
        end
      end
      LD_RUN: begin
        cpu_rst = 1'b0;
        // A restart takes priority over a same-cycle processor store.
        if (cpu_write && !ld_start) begin
          ram_we    = 1'b1;
          ram_waddr = cpu_addr;
          ram_wdata = cpu_wdata;
        end
      end
      default: begin
        state_next = LD_IDLE;
      end
    endcase

    if (start_ok) begin
      wr_ptr_next   = '0;
      remain_next   = len_clamped;
      hold_cnt_next = '0;
      state_next    = (len_clamped == '0) ? LD_HOLD : LD_LOAD;
    end
  end

  assign ld_done = done_reg;

  spm_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(cpu_addr),
    .rdata(cpu_rdata)
  );

endmodule

// File: tb/tb_spm_prog_loader.sv
// Directed self-checking bench for spm_prog_loader (RST_HOLD = 2).
module tb_spm_prog_loader;
  import spm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_start = 1'b0;
  logic [8:0] ld_len = '0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, ld_busy, ld_done, cpu_rst;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] bytes_a [4] = '{8'h91, 8'h00, 8'h25, 8'hF0};
  logic [7:0] bytes_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  spm_prog_loader #(.ADDR_W(8), .DATA_W(8), .RST_HOLD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .cpu_rst  (cpu_rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_mem(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    cpu_addr = addr;
    @(negedge clk);
    check(tag, cpu_rdata, exp);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (ld_done) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_busy", ld_busy, 1'b0);
    check("rst_done", ld_done, 1'b0);
    check("rst_wr_ptr", dut.wr_ptr_reg, 8'h00);
    check("rst_hold_cnt", dut.hold_cnt_reg, 2'd0);
    rst = 1'b0;
    tick();

    // ---- back-to-back load of 4 bytes ----
    ld_len = 9'd4; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t2_ready_load", ld_ready, 1'b1);
    check("t2_busy_load", ld_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = bytes_a[i];
      tick();
    end
    ld_valid = 1'b0;
    check("t2_ready_fall", ld_ready, 1'b0);
    check("t2_busy_hold", ld_busy, 1'b1);
    check("t2_cpu_rst_e0", cpu_rst, 1'b1);
    tick();
    check("t2_cpu_rst_e1", cpu_rst, 1'b1);
    check("t2_done_e1", ld_done, 1'b0);
    tick();
    check("t2_cpu_rst_e2", cpu_rst, 1'b1);
    tick();
    check("t2_cpu_rst_e3", cpu_rst, 1'b0);
    check("t2_done_e3", ld_done, 1'b1);
    check("t2_busy_run", ld_busy, 1'b0);
    tick();
    check("t2_done_e4", ld_done, 1'b0);
    for (int i = 0; i < 4; i++) read_mem("t2_mem", 8'(i), bytes_a[i]);
    $display("load len=4 back-to-back complete");

    // ---- reset keeps memory ----
    rst = 1'b1;
    repeat (3) tick();
    check("t1_cpu_rst", cpu_rst, 1'b1);
    check("t1_ready", ld_ready, 1'b0);
    check("t1_busy", ld_busy, 1'b0);
    check("t1_done", ld_done, 1'b0);
    read_mem("t1_mem0_kept", 8'h00, 8'h91);
    rst = 1'b0;
    tick();

    // ---- load with ld_valid toggling ----
    ld_len = 9'd4; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    begin
      int n;
      n = 0;
      for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
        ld_valid = (cyc % 2 == 0);
        ld_data  = ld_valid ? bytes_b[n] : 8'hEE;
        tick();
        if (ld_valid) n++;
      end
    end
    ld_valid = 1'b0;
    check("t3_wr_ptr", dut.wr_ptr_reg, 8'h04);
    check("t3_ready_fall", ld_ready, 1'b0);
    wait_done("t3_done_seen");
    for (int i = 0; i < 4; i++) read_mem("t3_mem", 8'(i), bytes_b[i]);
    $display("load len=4 with gaps complete");

    // ---- full 256-byte load, started from RUN ----
    ld_len = 9'd256; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t4_cpu_rst_rise", cpu_rst, 1'b1);
    check("t4_ready", ld_ready, 1'b1);
    check("t4_wr_ptr0", dut.wr_ptr_reg, 8'h00);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A;
      tick();
    end
    check("t4_ready_fall", ld_ready, 1'b0);
    ld_data = 8'h77;  // extra beat in HOLD must not land at address 0
    tick();
    ld_valid = 1'b0;
    wait_done("t4_done_seen");
    read_mem("t4_mem255", 8'hFF, 8'hA5);
    read_mem("t4_mem0", 8'h00, 8'h5A);
    read_mem("t4_mem80", 8'h80, 8'hDA);
    $display("load len=256 complete");

    // ---- oversize length clamps to 256 ----
    ld_len = 9'h1FF; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A;
      tick();
    end
    ld_valid = 1'b0;
    check("t4_clamp_ready", ld_ready, 1'b0);
    wait_done("t4_clamp_done");
    $display("load len=511 clamped complete");

    // ---- cpu writes in RUN vs LOAD ----
    cpu_addr = 8'h80; cpu_wdata = 8'h3C; cpu_write = 1'b1;
    #1;
    check("t5_rdw_old", cpu_rdata, 8'hDA);
    tick();
    cpu_write = 1'b0;
    check("t5_write_new", cpu_rdata, 8'h3C);
    $display("cpu write addr=80 data=3c");
    ld_len = 9'd4; ld_start = 1'b1;
    cpu_addr = 8'h81; cpu_wdata = 8'h99; cpu_write = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t5_restart_cpu_rst", cpu_rst, 1'b1);
    cpu_addr = 8'h80; cpu_wdata = 8'h55; cpu_write = 1'b1;
    ld_start = 1'b1; ld_len = 9'd0;  // ignored during LOAD
    tick();
    cpu_write = 1'b0; ld_start = 1'b0;
    #1;
    check("t5_load_write_dropped", cpu_rdata, 8'h3C);
    check("t5_start_ignored", ld_ready, 1'b1);
    cpu_addr = 8'h81;
    #1;
    check("t5_collide_write_dropped", cpu_rdata, 8'hDB);

    // ---- reset mid-load keeps partial bytes ----
    ld_valid = 1'b1; ld_data = 8'hAA;
    tick();
    ld_data = 8'hBB;
    tick();
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_rst_ready", ld_ready, 1'b0);
    check("t6_rst_busy", ld_busy, 1'b0);
    check("t6_rst_cpu_rst", cpu_rst, 1'b1);
    rst = 1'b0;
    tick();
    read_mem("t6_mem0", 8'h00, 8'hAA);
    read_mem("t6_mem1", 8'h01, 8'hBB);
    read_mem("t6_mem2", 8'h02, 8'h58);
    $display("reset mid-load after 2 bytes");

    // ---- zero-length load goes straight to HOLD ----
    ld_len = 9'd0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t6z_busy", ld_busy, 1'b1);
    check("t6z_ready", ld_ready, 1'b0);
    check("t6z_cpu_rst_e0", cpu_rst, 1'b1);
    tick();
    check("t6z_cpu_rst_e1", cpu_rst, 1'b1);
    tick();
    check("t6z_cpu_rst_e2", cpu_rst, 1'b1);
    tick();
    check("t6z_cpu_rst_e3", cpu_rst, 1'b0);
    check("t6z_done", ld_done, 1'b1);
    read_mem("t6z_mem0", 8'h00, 8'hAA);
    $display("load len=0 complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
